// File: rtl/error_counter_pkg.sv
// Shared constants for the tap-sweep error counter: FSM encoding, PRBS7 definition
// and a width helper.
package error_counter_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETTLE = 3'd1,
      ST_COUNT  = 3'd2,
      ST_STORE  = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   // x^7 + x^6 + 1: feedback from register bits 6 and 5
   localparam logic [6:0] PRBS7_SEED = 7'h7F;
   localparam logic [6:0] PRBS7_TAPS = 7'b110_0000;

   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/error_counter_if.sv
// Result port bundle of the error counter: strobe plus packed per-tap counts.
interface error_counter_if #(
   parameter int DAT_W = 32
);
   logic             o_stb;
   logic [DAT_W-1:0] o_dat;

   modport master (output o_stb, output o_dat);
   modport slave  (input  o_stb, input  o_dat);
endinterface

// File: rtl/prbs7_gen.sv
// Free-running PRBS7 source; output is the register MSB.
module prbs7_gen
   import error_counter_pkg::*;
(
   input  logic CLK,
   input  logic RST,
   input  logic enable,
   output logic prbs_out
);

   logic [6:0] lfsr_q, lfsr_d;

   always_comb begin
      lfsr_d = lfsr_q;
      if (enable) lfsr_d = {lfsr_q[5:0], ^(lfsr_q & PRBS7_TAPS)};
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) lfsr_q <= PRBS7_SEED;
      else      lfsr_q <= lfsr_d;
   end

   assign prbs_out = lfsr_q[6];

endmodule

// File: rtl/error_counter.sv
// Sweeps a PRBS7 stream across delay taps and counts mismatches against tap 0 per tap.
//
// state  | meaning
// IDLE   | select tap 0, clear working counter
// SETTLE | let the newly selected tap settle, no counting
// COUNT  | count reference/test mismatches for WINDOW cycles
// STORE  | park count in the tap's result slot, advance tap
// DONE   | present results on O_DAT with O_STB
module error_counter
   import error_counter_pkg::*;
#(
   parameter int COUNT_WIDTH = 8,
   parameter int DELAY_TAPS  = 4,
   parameter int WINDOW      = 32,
   parameter int SETTLE      = 2
)(
   input  logic                              CLK,
   input  logic                              RST,
   output logic                              O_STB,
   output logic [DELAY_TAPS*COUNT_WIDTH-1:0] O_DAT
);

   localparam int TAP_W = clog2_min1(DELAY_TAPS);
   localparam int TMR_W = clog2_min1((WINDOW > SETTLE) ? WINDOW : SETTLE);
   localparam int RES_W = DELAY_TAPS * COUNT_WIDTH;

   localparam logic [TMR_W-1:0]       WIN_LOAD = TMR_W'(WINDOW - 1);
   localparam logic [TMR_W-1:0]       SET_LOAD = TMR_W'((SETTLE > 0) ? SETTLE - 1 : 0);
   localparam logic [TAP_W-1:0]       TAP_LAST = TAP_W'(DELAY_TAPS - 1);
   localparam logic [COUNT_WIDTH-1:0] CNT_MAX  = '1;

   state_t                 state_q, state_d;
   logic [TAP_W-1:0]       tap_q, tap_d;
   logic [TMR_W-1:0]       tmr_q, tmr_d;
   logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [RES_W-1:0]       res_q, res_d;
   logic [RES_W-1:0]       dat_q, dat_d;
   logic                   stb_q, stb_d;
   logic                   prbs_bit, test_bit, err;

   prbs7_gen u_prbs (
      .CLK      (CLK),
      .RST      (RST),
      .enable   (1'b1),
      .prbs_out (prbs_bit)
   );

   // Shift line bit i holds the PRBS bit delayed i+1 cycles; tap 0 is the live bit.
   generate
      if (DELAY_TAPS > 1) begin : g_line
         logic [DELAY_TAPS-2:0] line_q, line_d;
         logic [DELAY_TAPS-1:0] tap_vec;

         always_comb begin
            line_d = (DELAY_TAPS-1)'({line_q, prbs_bit});
         end

         always_ff @(posedge CLK or negedge RST) begin
            if (!RST) line_q <= '0;
            else      line_q <= line_d;
         end

         assign tap_vec  = {line_q, prbs_bit};
         assign test_bit = tap_vec[tap_q];
      end else begin : g_no_line
         assign test_bit = prbs_bit;
      end
   endgenerate

   assign err = prbs_bit ^ test_bit;

   always_comb begin
      state_d = state_q;
      tap_d   = tap_q;
      tmr_d   = tmr_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      dat_d   = dat_q;
      stb_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            tap_d = '0;
            cnt_d = '0;
            if (SETTLE > 0) begin
               state_d = ST_SETTLE;
               tmr_d   = SET_LOAD;
            end else begin
               state_d = ST_COUNT;
               tmr_d   = WIN_LOAD;
            end
         end
         ST_SETTLE: begin
            if (tmr_q == '0) begin
               state_d = ST_COUNT;
               tmr_d   = WIN_LOAD;
            end else begin
               tmr_d = tmr_q - TMR_W'(1);
            end
         end
         ST_COUNT: begin
            if (err && (cnt_q != CNT_MAX)) cnt_d = cnt_q + COUNT_WIDTH'(1);
            if (tmr_q == '0) state_d = ST_STORE;
            else             tmr_d   = tmr_q - TMR_W'(1);
         end
         ST_STORE: begin
            for (int k = 0; k < DELAY_TAPS; k++) begin
               if (tap_q == TAP_W'(k)) res_d[k*COUNT_WIDTH +: COUNT_WIDTH] = cnt_q;
            end
            cnt_d = '0;
            // Output register loads on entry so O_DAT is already valid while O_STB is high.
            if (tap_q == TAP_LAST) begin
               state_d = ST_DONE;
               dat_d   = res_d;
               stb_d   = 1'b1;
            end else begin
               tap_d = tap_q + TAP_W'(1);
               if (SETTLE > 0) begin
                  state_d = ST_SETTLE;
                  tmr_d   = SET_LOAD;
               end else begin
                  state_d = ST_COUNT;
                  tmr_d   = WIN_LOAD;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= ST_IDLE;
         tap_q   <= '0;
         tmr_q   <= '0;
         cnt_q   <= '0;
         res_q   <= '0;
         dat_q   <= '0;
         stb_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tap_q   <= tap_d;
         tmr_q   <= tmr_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         dat_q   <= dat_d;
         stb_q   <= stb_d;
      end
   end

   assign O_STB = stb_q;
   assign O_DAT = dat_q;

endmodule

// File: tb/tb_error_counter.sv
// Directed + randomized-reset bench for error_counter against a PRBS7 sequence model.
module tb_error_counter;

   localparam int PER_A = 142;
   localparam int PER_B = 142;
   localparam int PER_C = 7;

   logic clk = 1'b0;
   logic rst = 1'b0;

   int checks = 0;
   int errors = 0;

   bit          p [0:2047];
   logic [31:0] hold_a, hold_b, hold_c;

   error_counter_if #(.DAT_W(32)) if_a ();
   error_counter_if #(.DAT_W(12)) if_b ();
   error_counter_if #(.DAT_W(8))  if_c ();

   error_counter #(.COUNT_WIDTH(8), .DELAY_TAPS(4), .WINDOW(32), .SETTLE(2)) dut_a (
      .CLK(clk), .RST(rst), .O_STB(if_a.o_stb), .O_DAT(if_a.o_dat));

   error_counter #(.COUNT_WIDTH(3), .DELAY_TAPS(4), .WINDOW(32), .SETTLE(2)) dut_b (
      .CLK(clk), .RST(rst), .O_STB(if_b.o_stb), .O_DAT(if_b.o_dat));

   error_counter #(.COUNT_WIDTH(8), .DELAY_TAPS(1), .WINDOW(4), .SETTLE(0)) dut_c (
      .CLK(clk), .RST(rst), .O_STB(if_c.o_stb), .O_DAT(if_c.o_dat));

   always #5 clk = ~clk;

   task automatic check(input string tag, input int cyc, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   // Errors counted for tap k in a given sweep; cycle numbering restarts at each reset release.
   function automatic int model_slot(input int t_n, input int s_n, input int w_n,
                                     input int c_w, input int sweep, input int k);
      int per, start, cnt, lim;
      per   = 2 + t_n * (s_n + w_n + 1);
      start = 2 + sweep * per + k * (s_n + w_n + 1) + s_n;
      cnt   = 0;
      for (int c = start; c < start + w_n; c++) begin
         if (p[c] != ((c - k >= 1) ? p[c - k] : 1'b0)) cnt++;
      end
      lim = (1 << c_w) - 1;
      return (cnt > lim) ? lim : cnt;
   endfunction

   task automatic run_phase(input int first, input int ncyc);
      for (int cyc = first; cyc < first + ncyc; cyc++) begin
         if (cyc % PER_A == 0) begin
            hold_a = '0;
            for (int k = 0; k < 4; k++)
               hold_a[k*8 +: 8] = 8'(model_slot(4, 2, 32, 8, cyc / PER_A - 1, k));
         end
         if (cyc % PER_B == 0) begin
            hold_b = '0;
            for (int k = 0; k < 4; k++)
               hold_b[k*3 +: 3] = 3'(model_slot(4, 2, 32, 3, cyc / PER_B - 1, k));
         end
         if (cyc % PER_C == 0) begin
            hold_c = '0;
            hold_c[7:0] = 8'(model_slot(1, 0, 4, 8, cyc / PER_C - 1, 0));
         end
         check("a_stb", cyc, 32'(if_a.o_stb), 32'(cyc % PER_A == 0));
         check("a_dat", cyc, 32'(if_a.o_dat), hold_a);
         check("b_stb", cyc, 32'(if_b.o_stb), 32'(cyc % PER_B == 0));
         check("b_dat", cyc, 32'(if_b.o_dat), hold_b);
         check("c_stb", cyc, 32'(if_c.o_stb), 32'(cyc % PER_C == 0));
         check("c_dat", cyc, 32'(if_c.o_dat), hold_c);
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic reset_checks(input string tag);
      check({tag, "_a_stb"}, 0, 32'(if_a.o_stb), 32'd0);
      check({tag, "_a_dat"}, 0, 32'(if_a.o_dat), 32'd0);
      check({tag, "_b_stb"}, 0, 32'(if_b.o_stb), 32'd0);
      check({tag, "_b_dat"}, 0, 32'(if_b.o_dat), 32'd0);
      check({tag, "_c_stb"}, 0, 32'(if_c.o_stb), 32'd0);
      check({tag, "_c_dat"}, 0, 32'(if_c.o_dat), 32'd0);
      hold_a = '0;
      hold_b = '0;
      hold_c = '0;
   endtask

   initial begin
      int n_run, n_hold;

      // PRBS7 output sequence: seven ones from the all-ones seed, then o[n] = o[n-7] ^ o[n-6].
      p[0] = 1'b0;
      for (int n = 1; n <= 7; n++) p[n] = 1'b1;
      for (int n = 8; n < 2048; n++) p[n] = p[n-7] ^ p[n-6];

      rst = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      reset_checks("por");
      rst = 1'b1;

      // Two full sweeps plus change, from cycle 1.
      run_phase(1, 290);

      // Fresh start, then reset at cycle 70 held for 3 cycles.
      rst = 1'b0;
      #1;
      reset_checks("rst0");
      @(negedge clk);
      rst = 1'b1;
      run_phase(1, 69);
      rst = 1'b0;
      #1;
      reset_checks("mid70");
      repeat (3) @(negedge clk);
      rst = 1'b1;
      run_phase(1, 150);

      // Reset at a random point with a random hold length.
      n_run  = int'($urandom_range(1, 130));
      n_hold = int'($urandom_range(1, 5));
      run_phase(151, n_run);
      rst = 1'b0;
      #1;
      reset_checks("rand");
      repeat (n_hold) @(negedge clk);
      rst = 1'b1;
      run_phase(1, 160);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
